clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider and tick generator. It replaces the team's fixed single-output toggle divider. Each channel produces a registered divided clock with a programmable period and high time, plus a one-cycle period-start tick. A write port lets firmware or a control FSM retune any channel, and the change takes effect glitch-free at that channel's next period boundary. The block sits next to the board clock and feeds slow clocks and enables to display, debounce and blink logic.

---
 rtl/clk_div_prog.sv | 109 ++++++++++
 tb/tb_clk_div_prog.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider and period-start tick generator.
// Each channel retunes glitch-free: written settings wait for that channel's next wrap.
module clk_div_prog #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 19,
  parameter int DEF_DIV  = 500000,
  parameter int DEF_HIGH = 250000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend,
  output logic              wr_err
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(DEF_DIV - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

  logic ch_ok;
  logic div_ok;
  logic wr_acc;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    ch_ok  = (32'(wr_ch) < 32'(NUM_CH));
    div_ok = (wr_div >= DIV_MIN);
    wr_acc = wr_en && ch_ok && div_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_en && !wr_acc;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] high_cur;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] high_pend;
    logic [CNT_W-1:0] high_next;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             wrap;

    always_comb begin
      cnt_inc   = cnt + ONE;
      wr_hit    = wr_acc && (wr_ch == CH_W'(i));
      wrap      = sync || (en[i] && (cnt == div_cur - ONE));
      high_next = pend_q ? high_pend : high_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt       <= CNT_RST;
        div_cur   <= DIV_RST;
        high_cur  <= HIGH_RST;
        div_pend  <= DIV_RST;
        high_pend <= HIGH_RST;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        // NOTE: non-blocking updates let a wrap apply the old pending values while
        // a same-cycle write loads the new ones; the new write is never applied here.
        if (wr_hit) begin
          div_pend  <= wr_div;
          high_pend <= wr_high;
        end
        if (wrap) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          clk_q  <= (high_next != '0);
          if (pend_q) begin
            div_cur  <= div_pend;
            high_cur <= high_pend;
          end
        end else begin
          tick_q <= 1'b0;
          if (en[i]) begin
            cnt   <= cnt_inc;
            clk_q <= (cnt_inc < high_cur);
          end
        end
        if (wr_hit)    pend_q <= 1'b1;
        else if (wrap) pend_q <= 1'b0;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pend[i]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (CNT_W=8, DEF_DIV=10, DEF_HIGH=5); expected
// bit patterns below are hand-derived cycle by cycle.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = '0;
  logic       sync = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_ch = 1'b0;
  logic [7:0] wr_div = '0;
  logic [7:0] wr_high = '0;
  logic [1:0] clk_out, tick, pend;
  logic       wr_err;

  // Three-channel instance so an out-of-range channel number is representable.
  logic       wr_en3 = 1'b0;
  logic [1:0] wr_ch3 = '0;
  logic [2:0] clk_out3, tick3, pend3;
  logic       wr_err3;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] cap_clk0, cap_clk1, cap_tick0, cap_tick1, cap_pend0, cap_pend1;

  always #5 clk = ~clk;

  clk_div_prog #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(10), .DEF_HIGH(5)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_high(wr_high), .clk_out(clk_out), .tick(tick),
    .pend(pend), .wr_err(wr_err)
  );

  clk_div_prog #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(10), .DEF_HIGH(5)) u_dut3 (
    .clk(clk), .rst(rst), .en(3'b000), .sync(sync), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_div(wr_div), .wr_high(wr_high), .clk_out(clk_out3), .tick(tick3),
    .pend(pend3), .wr_err(wr_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n cycles recording per-cycle outputs; bit k holds the value after edge k.
  task automatic run(input int n);
    cap_clk0 = '0; cap_clk1 = '0; cap_tick0 = '0;
    cap_tick1 = '0; cap_pend0 = '0; cap_pend1 = '0;
    for (int k = 0; k < n; k++) begin
      step();
      wr_en = 1'b0;
      cap_clk0[k]  = clk_out[0];
      cap_clk1[k]  = clk_out[1];
      cap_tick0[k] = tick[0];
      cap_tick1[k] = tick[1];
      cap_pend0[k] = pend[0];
      cap_pend1[k] = pend[1];
    end
  endtask

  task automatic write(input logic ch, input logic [7:0] dv, input logic [7:0] hi);
    wr_en = 1'b1; wr_ch = ch; wr_div = dv; wr_high = hi;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_pend",    32'(pend),    32'h0);
    check("rst_wr_err",  32'(wr_err),  32'h0);
    rst = 1'b0;
    repeat (2) step();
    check("idle_clk_out", 32'(clk_out), 32'h0);
    check("idle_tick",    32'(tick),    32'h0);

    // Default 5-high / 5-low, tick every 10, first tick one edge after en.
    en = 2'b11;
    run(20);
    check("def_clk0",  cap_clk0,  32'h7C1F);
    check("def_clk1",  cap_clk1,  32'h7C1F);
    check("def_tick0", cap_tick0, 32'h401);
    check("def_tick1", cap_tick1, 32'h401);

    // Mid-period retune of ch1 to div=4 high=1.
    repeat (3) step();
    write(1'b1, 8'd4, 8'd1);
    check("wr1_pend",   32'(pend),   32'h2);
    check("wr1_wr_err", 32'(wr_err), 32'h0);
    run(16);
    check("ret_clk1",  cap_clk1,  32'h4441);
    check("ret_tick1", cap_tick1, 32'h4440);
    check("ret_pend1", cap_pend1, 32'h3F);
    check("ret_tick0", cap_tick0, 32'h40);

    // Rejected writes.
    write(1'b0, 8'd1, 8'd3);
    check("div1_wr_err",  32'(wr_err),  32'h1);
    check("div1_pend",    32'(pend),    32'h0);
    check("div1_clk_out", 32'(clk_out), 32'h1);
    check("div1_tick",    32'(tick),    32'h1);
    step();
    check("div1_err_drop", 32'(wr_err), 32'h0);
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div = 8'd4; wr_high = 8'd1;
    step();
    wr_en3 = 1'b0;
    check("ch3_wr_err", 32'(wr_err3), 32'h1);
    check("ch3_pend",   32'(pend3),   32'h0);
    check("ch3_main_wr_err", 32'(wr_err), 32'h0);
    step();
    check("ch3_err_drop", 32'(wr_err3), 32'h0);

    // high=0 on ch0 (and a valid write to channel 2 of the 3-channel instance).
    wr_en3 = 1'b1; wr_ch3 = 2'd2;
    write(1'b0, 8'd10, 8'd0);
    wr_en3 = 1'b0;
    check("h0_pend",  32'(pend),  32'h1);
    check("h0_pend3", 32'(pend3), 32'h4);
    run(20);
    check("h0_clk0",  cap_clk0,  32'h0);
    check("h0_tick0", cap_tick0, 32'h8020);
    check("h0_pend0", cap_pend0, 32'h1F);

    // high=12 >= div=10 on ch0.
    write(1'b0, 8'd10, 8'd12);
    run(20);
    check("h12_clk0",  cap_clk0,  32'hFFFF0);
    check("h12_tick0", cap_tick0, 32'h4010);

    // Restore 5/10 on ch0, then freeze it for 7 cycles at cnt=2.
    write(1'b0, 8'd10, 8'd5);
    repeat (4) step();
    check("rest_clk0",  32'(clk_out[0]), 32'h1);
    check("rest_tick0", 32'(tick[0]),    32'h1);
    check("rest_pend0", 32'(pend[0]),    32'h0);
    repeat (2) step();
    en = 2'b10;
    run(7);
    check("frz_clk0",  cap_clk0,  32'h7F);
    check("frz_tick0", cap_tick0, 32'h0);
    en = 2'b11;
    run(10);
    check("res_clk0",  cap_clk0,  32'h383);
    check("res_tick0", cap_tick0, 32'h80);

    // sync restarts every channel, including disabled ones.
    sync = 1'b1; en = 2'b01;
    step();
    sync = 1'b0; en = 2'b11;
    check("sync_tick",    32'(tick),    32'h3);
    check("sync_clk_out", 32'(clk_out), 32'h3);
    check("sync_tick3",   32'(tick3),   32'h7);
    check("sync_pend3",   32'(pend3),   32'h0);
    step();
    check("sync_tick_drop", 32'(tick), 32'h0);

    // Asynchronous reset mid-period with a setting pending.
    write(1'b0, 8'd6, 8'd3);
    check("prst_pend", 32'(pend), 32'h1);
    step();
    check("prst_clk0", 32'(clk_out[0]), 32'h1);
    #3 rst = 1'b1;
    #1;
    check("arst_clk_out", 32'(clk_out), 32'h0);
    check("arst_pend",    32'(pend),    32'h0);
    check("arst_tick",    32'(tick),    32'h0);
    step();
    rst = 1'b0;

    // DEF settings active again; a write at the first wrap only becomes pending.
    wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd4; wr_high = 8'd2;
    run(20);
    check("post_clk0",  cap_clk0,  32'h7C1F);
    check("post_tick0", cap_tick0, 32'h401);
    check("post_pend0", cap_pend0, 32'h0);
    check("post_clk1",  cap_clk1,  32'hCCC1F);
    check("post_tick1", cap_tick1, 32'h44401);
    check("post_pend1", cap_pend1, 32'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
